// File: rtl/csa_stream_accum_if.sv
// Valid/ready bundle for csa_stream_accum: operand stream in, resolved sum out.
// out_ovf exists only when CSA_OVF_EN is defined.
interface csa_stream_accum_if #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
`ifdef CSA_OVF_EN
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_ovf
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt
  );
`endif
endinterface

// File: rtl/csa_stream_accum.sv
// Streaming N-operand adder: 3:2 carry-save fold per beat, chunked carry-propagate at packet end.
// Optional sticky overflow flag on out_ovf when CSA_OVF_EN is defined.
module csa_stream_accum #(
  parameter int WIDTH = 16,
  parameter int GUARD = 4,
  parameter int CHUNK = 8,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  csa_stream_accum_if.slave   bus
);
  localparam int ACC_W  = WIDTH + GUARD;
  localparam int NCHUNK = (ACC_W + CHUNK - 1) / CHUNK;
  localparam int PAD_W  = NCHUNK * CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW     = CHUNK + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {ACC, RESOLVE, DONE} state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] s, c, x;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PAD_W-1:0] s_pad, c_pad;
  logic [CW-1:0]    chunk_sum;
  logic             accept, done;

  assign x      = ACC_W'(bus.in_data);
  assign accept = bus.in_valid & bus.in_ready;
  assign done   = bus.out_valid & bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_next;
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ACC:     if (accept && bus.in_last) state_next = RESOLVE;
      RESOLVE: if (idx == LAST_IDX)       state_next = DONE;
      DONE:    if (done)                  state_next = ACC;
      default:                            state_next = ACC;
    endcase
  end

  // in_ready is gated by rst directly so nothing is accepted during the reset edge.
  always_comb begin
    bus.in_ready  = (state == ACC) && !rst;
    bus.out_valid = (state == DONE);
  end

  // Zero-padded views let the top chunk be partial without special-casing.
  always_comb begin
    s_pad     = PAD_W'(s);
    c_pad     = PAD_W'(c);
    chunk_sum = CW'(s_pad[int'(idx)*CHUNK +: CHUNK])
              + CW'(c_pad[int'(idx)*CHUNK +: CHUNK])
              + CW'(carry);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s     <= '0;
      c     <= '0;
      cnt   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        ACC: if (accept) begin
          s     <= s ^ c ^ x;
          c     <= ((s & c) | (s & x) | (c & x)) << 1;
          cnt   <= (cnt == '1) ? cnt : cnt + 1'b1;
          idx   <= '0;
          carry <= 1'b0;
        end
        RESOLVE: begin
          for (int b = 0; b < ACC_W; b++)
            if (b / CHUNK == int'(idx)) sum_q[b] <= chunk_sum[b % CHUNK];
          carry <= chunk_sum[CHUNK];
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) cnt_q <= cnt;
        end
        DONE: if (done) begin
          s   <= '0;
          c   <= '0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_sum = sum_q;
  assign bus.out_cnt = cnt_q;

`ifdef CSA_OVF_EN
  localparam logic [CNT_W-1:0] OVF_CNT = CNT_W'(2 ** GUARD);
  logic ovf;

  // Sticky: set when an operand beyond 2**GUARD arrives, cleared when the result is taken.
  always_ff @(posedge clk) begin
    if (rst)                          ovf <= 1'b0;
    else if (done)                    ovf <= 1'b0;
    else if (accept && cnt == OVF_CNT) ovf <= 1'b1;
  end

  assign bus.out_ovf = ovf;
`endif
endmodule

// File: tb/tb_csa_stream_accum.sv
// Randomized self-checking bench for csa_stream_accum against a plain-arithmetic packet-sum model.
// Build with CSA_OVF_EN defined to also check out_ovf.
module tb_csa_stream_accum;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  csa_stream_accum_if #(.WIDTH(16), .ACC_W(20), .CNT_W(8)) bus ();

  csa_stream_accum #(.WIDTH(16), .GUARD(4), .CHUNK(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with that edge's index.
  task automatic send_beat(input logic [15:0] x, input logic last, output int t_acc);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    bus.in_last  = last;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", bus.in_ready, 1);
    @(negedge clk);
    t_acc = cyc;
  endtask

  task automatic recv(input logic [19:0] exp_sum, input int n_ops, input int t_last,
                      input int hold, input bit rand_rdy);
    int n = 0;
    int k = 0;
    bit done = 0;
    logic [7:0] exp_cnt;
    exp_cnt = (n_ops > 255) ? 8'd255 : 8'(n_ops);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    while (!bus.out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_rise", bus.out_valid, 1);
    check("latency", cyc - t_last, 3);
    check("out_sum", bus.out_sum, exp_sum);
    check("out_cnt", bus.out_cnt, exp_cnt);
`ifdef CSA_OVF_EN
    check("out_ovf", bus.out_ovf, (n_ops > 16) ? 1 : 0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_sum", bus.out_sum, exp_sum);
      check("hold_in_ready", bus.in_ready, 0);
    end
    while (!done) begin
      bus.out_ready = (rand_rdy && k < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      done = bus.out_ready;
      k++;
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (!done) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_sum", bus.out_sum, exp_sum);
        check("stall_in_ready", bus.in_ready, 0);
      end
    end
    check("valid_drop", bus.out_valid, 0);
    check("in_ready_back", bus.in_ready, 1);
  endtask

  // Reference: packet result is the plain integer sum of operands, mod 2**20.
  task automatic run_packet(input logic [15:0] pkt[$], input bit bubbles,
                            input bit rand_rdy, input int hold);
    longint     acc = 0;
    int         t_last = 0;
    logic [19:0] exp_sum;
    foreach (pkt[i]) acc += longint'(pkt[i]);
    exp_sum = acc[19:0];
    foreach (pkt[i]) begin
      if (bubbles)
        while ($urandom_range(0, 3) == 0) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
        end
      send_beat(pkt[i], (i == pkt.size() - 1), t_last);
    end
    recv(exp_sum, pkt.size(), t_last, hold, rand_rdy);
  endtask

  initial begin
    logic [15:0] pkt[$];
    int t;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_sum", bus.out_sum, 0);
    check("reset_out_cnt", bus.out_cnt, 0);
`ifdef CSA_OVF_EN
    check("reset_out_ovf", bus.out_ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", bus.in_ready, 1);

    // Three-operand packet, back-to-back beats.
    pkt = '{16'h1234, 16'h0F0F, 16'hFFFF};
    run_packet(pkt, 0, 0, 0);

    // Single operand packet, then held for 5 cycles in DONE.
    pkt = '{16'hFFFF};
    run_packet(pkt, 0, 0, 5);
    pkt = '{16'h0001, 16'h0002};
    run_packet(pkt, 0, 0, 0);

    // Guard-bit boundary: 16 full operands exact, 17 wraps.
    pkt = {};
    repeat (16) pkt.push_back(16'hFFFF);
    run_packet(pkt, 0, 0, 0);
    pkt.push_back(16'hFFFF);
    run_packet(pkt, 0, 0, 0);

    // Operand counter saturation.
    pkt = {};
    repeat (260) pkt.push_back(16'h0001);
    run_packet(pkt, 0, 0, 0);

    // Reset during the second RESOLVE cycle discards the packet.
    send_beat(16'h1234, 1'b0, t);
    send_beat(16'h5678, 1'b1, t);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_cnt", bus.out_cnt, 0);
    check("midrst_out_sum", bus.out_sum, 0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_valid", bus.out_valid, 0);
    end
    check("midrst_in_ready_back", bus.in_ready, 1);
    pkt = '{16'h0005};
    run_packet(pkt, 0, 0, 0);

    // Three-operand packet with bubbles and random out_ready.
    pkt = '{16'h1234, 16'h0F0F, 16'hFFFF};
    run_packet(pkt, 1, 1, 0);

    // Random packets of 1..16 operands.
    for (int p = 0; p < 1000; p++) begin
      int len;
      len = $urandom_range(1, 16);
      pkt = {};
      for (int i = 0; i < len; i++) pkt.push_back(16'($urandom));
      run_packet(pkt, 1, 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
